// File: rtl/regfile_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : regfile_operand_fetch
// Description : Client-side operand fetch controller for a 2R/1W register
//               file with registered (1-cycle) read ports. Accepts one decode
//               request at a time, drives the RF read addresses, forwards
//               writebacks that land inside the read window, and presents
//               both operands with a valid/ready handshake. Writebacks are
//               passed straight through to the RF write port.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk              clock, all state updates on rising edge
//   rst              synchronous active-high reset
//   req_valid_i      decode request present
//   req_ready_o      controller can accept a request (IDLE only)
//   req_rs_i         source register A id
//   req_rt_i         source register B id
//   op_valid_o       operands valid
//   op_ready_i       consumer takes operands
//   op_a_o/op_b_o    operands A/B
//   wb_valid_i       writeback request (always accepted)
//   wb_id_i          writeback register id
//   wb_data_i        writeback data
//   rf_reg_id_r1_o   RF read port 1 address
//   rf_reg_id_r2_o   RF read port 2 address
//   rf_data_out1_i   RF read port 1 data (cycle after address sampled)
//   rf_data_out2_i   RF read port 2 data
//   rf_reg_id_w_o    RF write address (= wb_id_i)
//   rf_data_in_o     RF write data (= wb_data_i)
//   rf_wr_o          RF write enable
//   bypass_cnt_o     saturating count of forwarded operands
// ============================================================================
module regfile_operand_fetch #(
    parameter int N        = 32,
    parameter int R        = 32,
    parameter int ASIZE    = $clog2(R),
    parameter int ZERO_REG = 1,
    parameter int CW       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [ASIZE-1:0] req_rs_i,
    input  logic [ASIZE-1:0] req_rt_i,
    output logic             op_valid_o,
    input  logic             op_ready_i,
    output logic [N-1:0]     op_a_o,
    output logic [N-1:0]     op_b_o,
    input  logic             wb_valid_i,
    input  logic [ASIZE-1:0] wb_id_i,
    input  logic [N-1:0]     wb_data_i,
    output logic [ASIZE-1:0] rf_reg_id_r1_o,
    output logic [ASIZE-1:0] rf_reg_id_r2_o,
    input  logic [N-1:0]     rf_data_out1_i,
    input  logic [N-1:0]     rf_data_out2_i,
    output logic [ASIZE-1:0] rf_reg_id_w_o,
    output logic [N-1:0]     rf_data_in_o,
    output logic             rf_wr_o,
    output logic [CW-1:0]    bypass_cnt_o
);

    localparam logic c_ZERO_EN = (ZERO_REG != 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_CAPT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [ASIZE-1:0] id_a_q, id_a_d;
    logic [ASIZE-1:0] id_b_q, id_b_d;
    logic [N-1:0]     byp_a_q, byp_a_d;
    logic [N-1:0]     byp_b_q, byp_b_d;
    logic             flag_a_q, flag_a_d;
    logic             flag_b_q, flag_b_d;
    logic [N-1:0]     op_a_q, op_a_d;
    logic [N-1:0]     op_b_q, op_b_d;
    logic             op_valid_q, op_valid_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // Per-operand selection used in CAPT. A writeback arriving in CAPT is
    // younger than one saved during READ, so it takes precedence over the flag.
    logic             w_zero_a, w_zero_b;
    logic             w_hit_a, w_hit_b;
    logic             w_fwd_a, w_fwd_b;
    logic [N-1:0]     w_sel_a, w_sel_b;
    logic [1:0]       w_inc;
    logic [CW:0]      w_cnt_sum;
    logic [CW-1:0]    w_cnt_sat;

    assign w_zero_a = c_ZERO_EN && (id_a_q == '0);
    assign w_zero_b = c_ZERO_EN && (id_b_q == '0);
    assign w_hit_a  = wb_valid_i && (wb_id_i == id_a_q);
    assign w_hit_b  = wb_valid_i && (wb_id_i == id_b_q);
    // Reads of the hard-wired zero register are never counted as forwards.
    assign w_fwd_a  = !w_zero_a && (w_hit_a || flag_a_q);
    assign w_fwd_b  = !w_zero_b && (w_hit_b || flag_b_q);

    assign w_sel_a = w_zero_a ? '0 :
                     w_hit_a  ? wb_data_i :
                     flag_a_q ? byp_a_q : rf_data_out1_i;
    assign w_sel_b = w_zero_b ? '0 :
                     w_hit_b  ? wb_data_i :
                     flag_b_q ? byp_b_q : rf_data_out2_i;

    // Saturating add of 0..2; the extra MSB flags overflow.
    assign w_inc     = {1'b0, w_fwd_a} + {1'b0, w_fwd_b};
    assign w_cnt_sum = {1'b0, cnt_q} + {{(CW-1){1'b0}}, w_inc};
    assign w_cnt_sat = w_cnt_sum[CW] ? {CW{1'b1}} : w_cnt_sum[CW-1:0];

    always_comb begin
        state_d    = state_q;
        id_a_d     = id_a_q;
        id_b_d     = id_b_q;
        byp_a_d    = byp_a_q;
        byp_b_d    = byp_b_q;
        flag_a_d   = flag_a_q;
        flag_b_d   = flag_b_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_valid_d = op_valid_q;
        cnt_d      = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    id_a_d   = req_rs_i;
                    id_b_d   = req_rt_i;
                    flag_a_d = 1'b0;
                    flag_b_d = 1'b0;
                    state_d  = S_READ;
                end
            end
            S_READ: begin
                // The RF samples the addresses at the end of this cycle and
                // would return pre-write data, so catch the writeback here.
                if (w_hit_a) begin
                    byp_a_d  = wb_data_i;
                    flag_a_d = 1'b1;
                end
                if (w_hit_b) begin
                    byp_b_d  = wb_data_i;
                    flag_b_d = 1'b1;
                end
                state_d = S_CAPT;
            end
            S_CAPT: begin
                op_a_d     = w_sel_a;
                op_b_d     = w_sel_b;
                op_valid_d = 1'b1;
                cnt_d      = w_cnt_sat;
                state_d    = S_HOLD;
            end
            S_HOLD: begin
                // Operands stay frozen; any writeback now is younger.
                if (op_ready_i) begin
                    op_valid_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            id_a_q     <= '0;
            id_b_q     <= '0;
            byp_a_q    <= '0;
            byp_b_q    <= '0;
            flag_a_q   <= 1'b0;
            flag_b_q   <= 1'b0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_valid_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            id_a_q     <= id_a_d;
            id_b_q     <= id_b_d;
            byp_a_q    <= byp_a_d;
            byp_b_q    <= byp_b_d;
            flag_a_q   <= flag_a_d;
            flag_b_q   <= flag_b_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_valid_q <= op_valid_d;
            cnt_q      <= cnt_d;
        end
    end

    assign req_ready_o    = (state_q == S_IDLE);
    assign op_valid_o     = op_valid_q;
    assign op_a_o         = op_a_q;
    assign op_b_o         = op_b_q;
    assign rf_reg_id_r1_o = id_a_q;
    assign rf_reg_id_r2_o = id_b_q;
    assign rf_reg_id_w_o  = wb_id_i;
    assign rf_data_in_o   = wb_data_i;
    assign rf_wr_o        = wb_valid_i && !rst && !(c_ZERO_EN && (wb_id_i == '0));
    assign bypass_cnt_o   = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_operand_fetch
// Description : Self-checking bench for regfile_operand_fetch. Contains a
//               behavioural register file with registered reads and a
//               reference memory giving, for each request, the register
//               contents as seen after every write up to the capture cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_operand_fetch;

    localparam int c_N    = 32;
    localparam int c_AS   = 5;
    localparam int c_CW   = 3;
    localparam int c_CMAX = 7;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid_i, req_ready_o;
    logic [c_AS-1:0]   req_rs_i, req_rt_i;
    logic              op_valid_o, op_ready_i;
    logic [c_N-1:0]    op_a_o, op_b_o;
    logic              wb_valid_i;
    logic [c_AS-1:0]   wb_id_i;
    logic [c_N-1:0]    wb_data_i;
    logic [c_AS-1:0]   rf_reg_id_r1_o, rf_reg_id_r2_o, rf_reg_id_w_o;
    logic [c_N-1:0]    rf_data_out1_i, rf_data_out2_i, rf_data_in_o;
    logic              rf_wr_o;
    logic [c_CW-1:0]   bypass_cnt_o;

    int checks = 0;
    int errors = 0;

    logic [c_N-1:0] rf_mem  [32];
    logic [c_N-1:0] ref_mem [32];
    logic           rf_clr;
    logic [c_CW-1:0] exp_cnt;

    always #5 clk = ~clk;

    regfile_operand_fetch #(.N(c_N), .R(32), .ASIZE(c_AS), .ZERO_REG(1), .CW(c_CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_rs_i       (req_rs_i),
        .req_rt_i       (req_rt_i),
        .op_valid_o     (op_valid_o),
        .op_ready_i     (op_ready_i),
        .op_a_o         (op_a_o),
        .op_b_o         (op_b_o),
        .wb_valid_i     (wb_valid_i),
        .wb_id_i        (wb_id_i),
        .wb_data_i      (wb_data_i),
        .rf_reg_id_r1_o (rf_reg_id_r1_o),
        .rf_reg_id_r2_o (rf_reg_id_r2_o),
        .rf_data_out1_i (rf_data_out1_i),
        .rf_data_out2_i (rf_data_out2_i),
        .rf_reg_id_w_o  (rf_reg_id_w_o),
        .rf_data_in_o   (rf_data_in_o),
        .rf_wr_o        (rf_wr_o),
        .bypass_cnt_o   (bypass_cnt_o)
    );

    // Register file: registered reads return the pre-write value on a
    // same-cycle read/write collision.
    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= '0;
        end else if (rf_wr_o) begin
            rf_mem[rf_reg_id_w_o] <= rf_data_in_o;
        end
        rf_data_out1_i <= rf_mem[rf_reg_id_r1_o];
        rf_data_out2_i <= rf_mem[rf_reg_id_r2_o];
    end

    initial begin
        #300000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

    function automatic logic [c_CW-1:0] sat_add(input logic [c_CW-1:0] c, input int h);
        int t;
        t = int'(c) + h;
        if (t > c_CMAX) t = c_CMAX;
        return t[c_CW-1:0];
    endfunction

    // One idle-cycle writeback; reports the rf_wr seen during that cycle.
    task automatic wb_write(input logic [c_AS-1:0] id, input logic [c_N-1:0] d,
                            output logic wr_seen);
        wb_valid_i = 1'b1;
        wb_id_i    = id;
        wb_data_i  = d;
        @(negedge clk);
        wr_seen = rf_wr_o;
        if (id != 0) ref_mem[id] = d;
        @(posedge clk); #1;
        wb_valid_i = 1'b0;
    endtask

    // Runs one request: cycles c0..c3 carry the given writebacks, then the
    // operands are held for 'stall' cycles before being taken.
    task automatic do_req(input logic [c_AS-1:0] rs, input logic [c_AS-1:0] rt,
                          input logic [3:0] wv, input logic [3:0][c_AS-1:0] wid,
                          input logic [3:0][c_N-1:0] wd, input int stall,
                          output logic [c_N-1:0] ga, output logic [c_N-1:0] gb,
                          output logic [c_N-1:0] ea, output logic [c_N-1:0] eb,
                          output int hits, output logic lat_ok,
                          output logic stable_ok, output logic rel_ok,
                          output logic tmo);
        int  n;
        logic ha, hb;
        tmo = 1'b0; lat_ok = 1'b1; stable_ok = 1'b1; ha = 1'b0; hb = 1'b0;
        ga = '0; gb = '0; ea = '0; eb = '0;
        n = 0;
        while (!req_ready_o && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready_o) tmo = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req_valid_i = (k == 0);
            req_rs_i    = rs;
            req_rt_i    = rt;
            op_ready_i  = 1'b0;
            wb_valid_i  = wv[k];
            wb_id_i     = wid[k];
            wb_data_i   = wd[k];
            @(negedge clk);
            if (k < 3 && op_valid_o) lat_ok = 1'b0;
            if (k == 3 && op_valid_o !== 1'b1) lat_ok = 1'b0;
            if (wv[k] && wid[k] != 0) ref_mem[wid[k]] = wd[k];
            if ((k == 1 || k == 2) && wv[k]) begin
                if (wid[k] == rs && rs != 0) ha = 1'b1;
                if (wid[k] == rt && rt != 0) hb = 1'b1;
            end
            if (k == 2) begin
                ea = (rs == 0) ? '0 : ref_mem[rs];
                eb = (rt == 0) ? '0 : ref_mem[rt];
            end
            if (k == 3) begin
                ga = op_a_o;
                gb = op_b_o;
            end
            @(posedge clk); #1;
        end
        req_valid_i = 1'b0;
        wb_valid_i  = 1'b0;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            if (op_valid_o !== 1'b1 || op_a_o !== ga || op_b_o !== gb) stable_ok = 1'b0;
            @(posedge clk); #1;
        end
        op_ready_i = 1'b1;
        @(negedge clk);
        if (op_valid_o !== 1'b1 || op_a_o !== ga || op_b_o !== gb) stable_ok = 1'b0;
        @(posedge clk); #1;
        op_ready_i = 1'b0;
        rel_ok = (req_ready_o === 1'b1) && (op_valid_o === 1'b0);
        hits = int'(ha) + int'(hb);
    endtask

    task automatic test_reset;
        rst = 1'b1; rf_clr = 1'b1;
        req_valid_i = 1'b0; req_rs_i = '0; req_rt_i = '0; op_ready_i = 1'b0;
        wb_valid_i = 1'b1; wb_id_i = 5'd3; wb_data_i = 32'h1234;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (rf_wr_o !== 1'b0) begin
            errors++; $display("FAIL reset_rf_wr got %b want 0", rf_wr_o);
        end
        @(posedge clk); #1;
        checks++;
        if (req_ready_o !== 1'b1 || op_valid_o !== 1'b0) begin
            errors++; $display("FAIL reset_hs got ready=%b valid=%b want ready=1 valid=0", req_ready_o, op_valid_o);
        end
        checks++;
        if (op_a_o !== '0 || op_b_o !== '0 || bypass_cnt_o !== '0) begin
            errors++; $display("FAIL reset_data got a=%h b=%h cnt=%0d want 0 0 0", op_a_o, op_b_o, bypass_cnt_o);
        end
        checks++;
        if (rf_reg_id_r1_o !== '0 || rf_reg_id_r2_o !== '0) begin
            errors++; $display("FAIL reset_ids got %0d %0d want 0 0", rf_reg_id_r1_o, rf_reg_id_r2_o);
        end
        rst = 1'b0; rf_clr = 1'b0; wb_valid_i = 1'b0;
        exp_cnt = '0;
    endtask

    task automatic test_basic;
        logic [c_N-1:0] ga, gb, ea, eb;
        int h; logic lo, so, ro, to, w;
        wb_write(5'd5, 32'd5, w);
        wb_write(5'd7, 32'd7, w);
        do_req(5'd5, 5'd7, 4'b0000, '0, '0, 3, ga, gb, ea, eb, h, lo, so, ro, to);
        exp_cnt = sat_add(exp_cnt, h);
        checks++;
        if (to || !lo) begin
            errors++; $display("FAIL basic_latency got tmo=%b lat_ok=%b want 0 1", to, lo);
        end
        checks++;
        if (ga !== 32'd5 || gb !== 32'd7) begin
            errors++; $display("FAIL basic_ops got %h %h want 5 7", ga, gb);
        end
        checks++;
        if (!so) begin
            errors++; $display("FAIL basic_stable got unstable want stable");
        end
        checks++;
        if (!ro) begin
            errors++; $display("FAIL basic_release got ready=%b valid=%b want 1 0", req_ready_o, op_valid_o);
        end
    endtask

    task automatic test_fwd_read;
        logic [c_N-1:0] ga, gb, ea, eb;
        int h; logic lo, so, ro, to;
        logic [3:0][c_AS-1:0] wid;
        logic [3:0][c_N-1:0]  wd;
        wid = '0; wd = '0;
        wid[1] = 5'd5; wd[1] = 32'hAA;
        do_req(5'd5, 5'd7, 4'b0010, wid, wd, 0, ga, gb, ea, eb, h, lo, so, ro, to);
        exp_cnt = sat_add(exp_cnt, h);
        checks++;
        if (ga !== ea || gb !== eb) begin
            errors++; $display("FAIL fwd_read_ops got %h %h want %h %h", ga, gb, ea, eb);
        end
        checks++;
        if (bypass_cnt_o !== exp_cnt) begin
            errors++; $display("FAIL fwd_read_cnt got %0d want %0d", bypass_cnt_o, exp_cnt);
        end
        checks++;
        if (rf_mem[5] !== ref_mem[5]) begin
            errors++; $display("FAIL fwd_read_rf got %h want %h", rf_mem[5], ref_mem[5]);
        end
    endtask

    task automatic test_double_fwd;
        logic [c_N-1:0] ga, gb, ea, eb;
        int h; logic lo, so, ro, to;
        logic [3:0][c_AS-1:0] wid;
        logic [3:0][c_N-1:0]  wd;
        wid = '0; wd = '0;
        wid[1] = 5'd9; wd[1] = 32'h11;
        wid[2] = 5'd9; wd[2] = 32'h55;
        wid[3] = 5'd9; wd[3] = 32'h77;
        do_req(5'd9, 5'd9, 4'b1110, wid, wd, 2, ga, gb, ea, eb, h, lo, so, ro, to);
        exp_cnt = sat_add(exp_cnt, h);
        checks++;
        if (ga !== 32'h55 || gb !== 32'h55) begin
            errors++; $display("FAIL double_fwd_ops got %h %h want 55 55", ga, gb);
        end
        checks++;
        if (bypass_cnt_o !== exp_cnt) begin
            errors++; $display("FAIL double_fwd_cnt got %0d want %0d", bypass_cnt_o, exp_cnt);
        end
        checks++;
        if (!so) begin
            errors++; $display("FAIL double_fwd_hold got unstable want frozen at 55");
        end
    endtask

    task automatic test_zero_reg;
        logic [c_N-1:0] ga, gb, ea, eb;
        int h; logic lo, so, ro, to, w;
        logic [3:0][c_AS-1:0] wid;
        logic [3:0][c_N-1:0]  wd;
        wb_write(5'd0, 32'hFFFF, w);
        checks++;
        if (w !== 1'b0) begin
            errors++; $display("FAIL zero_rf_wr got %b want 0", w);
        end
        wid = '0; wd = '0;
        wd[1] = 32'hBEEF; wd[2] = 32'hCAFE;
        do_req(5'd0, 5'd0, 4'b0110, wid, wd, 0, ga, gb, ea, eb, h, lo, so, ro, to);
        exp_cnt = sat_add(exp_cnt, h);
        checks++;
        if (ga !== '0 || gb !== '0) begin
            errors++; $display("FAIL zero_ops got %h %h want 0 0", ga, gb);
        end
        checks++;
        if (bypass_cnt_o !== exp_cnt) begin
            errors++; $display("FAIL zero_cnt got %0d want %0d", bypass_cnt_o, exp_cnt);
        end
    endtask

    task automatic test_reset_mid;
        logic [c_N-1:0] ga, gb, ea, eb;
        int h; logic lo, so, ro, to, w, seen;
        wb_write(5'd5, 32'd5, w);
        req_valid_i = 1'b1; req_rs_i = 5'd5; req_rt_i = 5'd7;
        @(posedge clk); #1;
        req_valid_i = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_cnt = '0;
        checks++;
        if (req_ready_o !== 1'b1 || op_valid_o !== 1'b0 || bypass_cnt_o !== exp_cnt) begin
            errors++; $display("FAIL rst_mid_state got ready=%b valid=%b cnt=%0d want 1 0 0", req_ready_o, op_valid_o, bypass_cnt_o);
        end
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (op_valid_o !== 1'b0) seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (seen) begin
            errors++; $display("FAIL rst_mid_valid got op_valid=1 want 0");
        end
        do_req(5'd5, 5'd7, 4'b0000, '0, '0, 0, ga, gb, ea, eb, h, lo, so, ro, to);
        exp_cnt = sat_add(exp_cnt, h);
        checks++;
        if (to || !lo || ga !== 32'd5 || gb !== 32'd7) begin
            errors++; $display("FAIL rst_mid_req got tmo=%b lat=%b a=%h b=%h want 0 1 5 7", to, lo, ga, gb);
        end
    endtask

    task automatic test_random;
        logic [c_N-1:0] ga, gb, ea, eb;
        int h; logic lo, so, ro, to;
        logic [c_AS-1:0] rs, rt;
        logic [3:0] wv;
        logic [3:0][c_AS-1:0] wid;
        logic [3:0][c_N-1:0]  wd;
        int pick;
        for (int it = 0; it < 40; it++) begin
            rs = c_AS'($urandom_range(0, 11));
            rt = c_AS'($urandom_range(0, 11));
            wv = 4'($urandom);
            for (int k = 0; k < 4; k++) begin
                pick = $urandom_range(0, 2);
                wid[k] = (pick == 0) ? rs : (pick == 1) ? rt : c_AS'($urandom_range(0, 11));
                wd[k]  = $urandom;
            end
            do_req(rs, rt, wv, wid, wd, $urandom_range(0, 2), ga, gb, ea, eb, h, lo, so, ro, to);
            exp_cnt = sat_add(exp_cnt, h);
            checks++;
            if (ga !== ea || gb !== eb) begin
                errors++; $display("FAIL rand_ops it=%0d got %h %h want %h %h", it, ga, gb, ea, eb);
            end
            checks++;
            if (to || !lo || !so || !ro) begin
                errors++; $display("FAIL rand_hs it=%0d got tmo=%b lat=%b stable=%b rel=%b want 0 1 1 1", it, to, lo, so, ro);
            end
            checks++;
            if (bypass_cnt_o !== exp_cnt) begin
                errors++; $display("FAIL rand_cnt it=%0d got %0d want %0d", it, bypass_cnt_o, exp_cnt);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) ref_mem[i] = '0;
        exp_cnt = '0;
        test_reset();
        test_basic();
        test_fwd_read();
        test_double_fwd();
        test_zero_reg();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
